// File: rtl/float_norm_pkg.sv
// Shared types and IEEE-754 single-precision field constants for float_norm_scale.
package float_norm_pkg;

  typedef enum logic [1:0] {
    LOAD,
    WAIT_REC,
    STREAM
  } norm_state_t;

  localparam int unsigned EXP_MSB      = 30;
  localparam int unsigned EXP_LSB      = 23;
  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;

endpackage

// File: rtl/float_norm_scale_floatmul.sv
// Combinational single-precision multiplier: denormals flush to zero,
// round-to-nearest-even, overflow saturates to infinity, canonical quiet NaN.
module floatMul
  import float_norm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  logic        sa, sb, s;
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0] prod;
  logic        norm, g, st, up;
  logic [22:0] frac;
  logic [23:0] frac_r;
  logic [9:0]  e;

  assign sa = a[DATA_WIDTH-1];
  assign sb = b[DATA_WIDTH-1];
  assign ea = a[EXP_MSB:EXP_LSB];
  assign eb = b[EXP_MSB:EXP_LSB];
  assign ma = a[EXP_LSB-1:0];
  assign mb = b[EXP_LSB-1:0];
  assign s  = sa ^ sb;

  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == EXP_ALL_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ALL_ONES) && (mb == '0);
  assign a_nan  = (ea == EXP_ALL_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ALL_ONES) && (mb != '0);

  assign prod = {24'd0, 1'b1, ma} * {24'd0, 1'b1, mb};

  always_comb begin
    norm = prod[47];
    if (norm) begin
      frac = prod[46:24];
      g    = prod[23];
      st   = |prod[22:0];
    end else begin
      frac = prod[45:23];
      g    = prod[22];
      st   = |prod[21:0];
    end
    up     = g & (st | frac[0]);
    frac_r = {1'b0, frac} + {23'd0, up};
    // Biased exponent sum fits in 10 bits; bit 9 flags an underflowed (negative) result.
    e = {2'b00, ea} + {2'b00, eb} - 10'd127 + {9'd0, norm} + {9'd0, frac_r[23]};

    y = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      y = {1'b0, EXP_ALL_ONES, 1'b1, 22'd0};
    end else if (a_inf || b_inf) begin
      y = {s, EXP_ALL_ONES, 23'd0};
    end else if (a_zero || b_zero) begin
      y = {s, 31'd0};
    end else if (e[9] || (e == 10'd0)) begin
      y = {s, 31'd0};
    end else if (e >= 10'd255) begin
      y = {s, EXP_ALL_ONES, 23'd0};
    end else begin
      y = {s, e[7:0], frac_r[22:0]};
    end
  end

endmodule

// File: rtl/float_norm_scale.sv
// Buffers one vector, captures 1/sum, streams buf[i]*rec with ready/valid.
// Optional: FLOAT_NORM_ZERO_GUARD_EN zeroes outputs when rec is zero/denormal/inf/NaN.
module float_norm_scale
  import float_norm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned VEC_LEN    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  rec_valid,
  input  logic [DATA_WIDTH-1:0] rec_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int unsigned CW = $clog2(VEC_LEN);
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  norm_state_t           state, state_nx;
  logic [CW-1:0]         wcnt, rcnt;
  logic                  rec_hit;
  logic [DATA_WIDTH-1:0] rec_q;
  logic [DATA_WIDTH-1:0] vbuf [VEC_LEN];
  logic [DATA_WIDTH-1:0] prod;
  logic                  accept, rec_take, out_hs, zero_out;

  floatMul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .a (vbuf[rcnt]),
    .b (rec_q),
    .y (prod)
  );

`ifdef FLOAT_NORM_ZERO_GUARD_EN
  assign zero_out = (rec_q[EXP_MSB:EXP_LSB] == '0) ||
                    (rec_q[EXP_MSB:EXP_LSB] == EXP_ALL_ONES);
`else
  assign zero_out = 1'b0;
`endif

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    accept    = in_valid && (state == LOAD);
    rec_take  = rec_valid && !rec_hit && (state != STREAM);
    out_hs    = 1'b0;
    state_nx  = state;
    unique case (state)
      LOAD: begin
        if (accept && (wcnt == LAST))
          state_nx = (rec_hit || rec_valid) ? STREAM : WAIT_REC;
      end
      WAIT_REC: begin
        if (rec_take) state_nx = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        out_last  = (rcnt == LAST);
        out_data  = zero_out ? '0 : prod;
        out_hs    = out_ready;
        if (out_ready && out_last) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      wcnt    <= '0;
      rcnt    <= '0;
      rec_hit <= 1'b0;
      rec_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept && (wcnt != LAST)) wcnt <= wcnt + 1'b1;
      if (rec_take) begin
        rec_q   <= rec_data;
        rec_hit <= 1'b1;
      end
      if (out_hs) begin
        if (rcnt == LAST) begin
          rcnt    <= '0;
          wcnt    <= '0;
          rec_hit <= 1'b0;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end
  end

  // Element storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept) vbuf[wcnt] <= in_data;
  end

endmodule

// File: doc/float_norm_scale.md
# float_norm_scale

Downstream consumer of the reciprocal stage in the CNN classifier head. Buffers one vector of `VEC_LEN` non-negative float activations (e.g. softmax exponentials), captures the single reciprocal value `1/sum` from the reciprocal unit, then streams out each buffered element multiplied by that reciprocal. The output is a normalized vector with a last-element flag, delivered under ready/valid flow control.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: float word width; IEEE-754 single layout.
- `VEC_LEN`, default 10: number of elements per vector; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input element valid.
- `in_ready`  out  1  block can accept an input element.
- `in_data`  in  DATA_WIDTH  input element.
- `rec_valid`  in  1  single-cycle strobe; reciprocal valid.
- `rec_data`  in  DATA_WIDTH  reciprocal value `1/sum`.
- `out_valid`  out  1  output element valid.
- `out_ready`  in  1  downstream accepts the output element.
- `out_data`  out  DATA_WIDTH  `buf[i] * rec`.
- `out_last`  out  1  high with the final element of the vector.

## Operation
- States:
  - `LOAD`: accepting elements.
  - `WAIT_REC`: buffer full, reciprocal not yet captured.
  - `STREAM`: emitting products.
- Reset state is `LOAD`, with `wcnt = rcnt = 0`, `rec_hit = 0`, `rec_q = 0`.
- `in_ready = (state == LOAD)`.
  - Each cycle with `in_valid && in_ready`, write `buf[wcnt]` and increment `wcnt`.
- Reciprocal capture:
  - When `rec_valid` is high in `LOAD` or `WAIT_REC` and `rec_hit == 0`, set `rec_q <= rec_data` and `rec_hit <= 1`.
  - Any further `rec_valid` is ignored until the vector completes.
  - `rec_valid` in `STREAM` is ignored.
- `LOAD` exit, on the accept with `wcnt == VEC_LEN-1`:
  - go to `STREAM` if `rec_hit` is set, or if `rec_valid` is high in that same cycle;
  - otherwise go to `WAIT_REC`.
- `WAIT_REC` → `STREAM` on the cycle `rec_valid` is captured.
- In `STREAM`:
  - `out_valid = 1` and `out_data = floatMul(buf[rcnt], rec_q)`.
  - `out_last = (rcnt == VEC_LEN-1)`.
  - On `out_valid && out_ready`, increment `rcnt`.
  - On the handshake with `out_last`: clear `wcnt`, `rcnt` and `rec_hit`, and return to `LOAD`.
- `out_data` and `out_last` are held stable while `out_valid && !out_ready`.
- Outside `STREAM`, `out_valid`, `out_last` and `out_data` are 0.
- Counters are `$clog2(VEC_LEN)` bits wide and never wrap. Every transition occurs at `VEC_LEN-1`.
- Arithmetic:
  - Multiplication uses the combinational single-precision float multiplier.
  - No rounding beyond the multiplier's own behaviour.
  - Signs pass through the multiplier unchanged.

## Timing
- Reset values:
  - `in_ready = 1`.
  - `out_valid = 0`, `out_last = 0`, `out_data = 0`.
- Buffer contents are not reset.
- Input throughput is 1 element per cycle; `VEC_LEN` cycles minimum to fill.
- The first `out_valid` is asserted on the cycle after the `STREAM` transition edge.
- Output throughput is 1 element per cycle while `out_ready` is high.
- Minimum vector period is `2*VEC_LEN` cycles; `LOAD` and `STREAM` do not overlap.
- Reset asserted mid-operation immediately forces the reset state. The partial vector and any captured reciprocal are discarded.

## Configuration
- `FLOAT_NORM_ZERO_GUARD_EN`
  - Defined: if the captured `rec_q` has exponent field all zeros (zero or denormal) or all ones (inf/NaN), every `out_data` of that vector is 0. Handshake and `out_last` timing are unchanged.
  - Undefined: products are output unconditionally.

## Structure
- Shared package `float_norm_pkg` holds:
  - the state enum `norm_state_t` (`LOAD`, `WAIT_REC`, `STREAM`);
  - the float field constants (`EXP_MSB = 30`, `EXP_LSB = 23`, `EXP_ALL_ONES = 8'hFF`).
- One sub-module instance: the existing `floatMul` (`DATA_WIDTH`) computing `buf[rcnt] * rec_q`.
- The buffer is a register array of `VEC_LEN` × `DATA_WIDTH`.

## Test plan
All scenarios use `VEC_LEN = 4`.
- **Basic:** feed `3F800000`, `40000000`, `40400000`, `40800000` back-to-back; `rec_data = 3E800000` mid-load; `out_ready = 1`.
  - Expect outputs `3E800000`, `3F000000`, `3F400000`, `3F800000`, with `out_last` only on the 4th.
  - Expect `out_valid` 1 cycle after the last accept.
- **Late reciprocal:** same inputs; `rec_valid` 5 cycles after the last accept.
  - Expect `in_ready = 0` during the wait.
  - Expect the first `out_valid` 1 cycle after the `rec_valid` strobe.
- **Backpressure:** toggle `out_ready` 1,0,0,1.
  - Expect `out_data` and `out_last` held stable while stalled, and exactly 4 handshakes.
- **Duplicate and simultaneous reciprocal:**
  - `rec_valid = 3F000000` coincident with the 4th input, then a second `rec_valid = 40000000` during `STREAM`.
  - Expect all outputs scaled by 0.5; the second strobe is ignored.
- **Reset mid-stream:** drop `rst_n` after 2 output handshakes.
  - Expect `out_valid = 0` and `in_ready = 1` immediately.
  - A fresh vector then produces correct results.
- **Zero guard:** with `FLOAT_NORM_ZERO_GUARD_EN` defined, send `rec_data = 7F800000`.
  - Expect 4 outputs all `00000000`, with `out_last` on the 4th.
